// File: rtl/toggle_handshake_rx.sv
// toggle_handshake_rx
//
// Receive side of a two-phase (toggle) request/acknowledge handshake.
// The remote request toggle is synchronized into clk, every level change
// becomes one event, the accompanying payload is captured and offered on a
// valid/ready output, and an acknowledge toggle is returned once the word is
// consumed. A second request arriving while a word is still pending is a
// protocol overrun: it is dropped and a sticky flag is raised.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst        - asynchronous active-high reset
//   req_tgl    - request toggle from the sender (asynchronous to clk)
//   req_data   - request payload, stable until ack_tgl changes
//   ack_tgl    - acknowledge toggle, one change per consumed word
//   out_valid  - out_data holds an unconsumed word
//   out_data   - captured payload (held until the next capture)
//   out_ready  - downstream accepts the word
//   evt_pulse  - one-cycle pulse per accepted event
//   overrun    - sticky protocol-violation flag
//   evt_count  - wrapping count of accepted events
module toggle_handshake_rx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_tgl,
  input  logic [WIDTH-1:0] req_data,
  output logic             ack_tgl,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             evt_pulse,
  output logic             overrun,
  output logic [15:0]      evt_count
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   ack_q, ack_d;
  logic                   out_valid_q, out_valid_d;
  logic [WIDTH-1:0]       out_data_q, out_data_d;
  logic                   evt_pulse_q, evt_pulse_d;
  logic                   overrun_q, overrun_d;
  logic [15:0]            evt_count_q, evt_count_d;
  logic                   req_edge_s;

  // Synchronizer shift and edge-reference update; only sync bit 0 sees req_tgl.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], req_tgl};
    prev_d     = sync_q[SYNC_STAGES-1];
    // Either polarity of toggle is one request.
    req_edge_s = sync_q[SYNC_STAGES-1] ^ prev_q;
  end

  // Next-state and output logic of the capture/hold handshake FSM.
  always_comb begin
    state_d     = state_q;
    ack_d       = ack_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    evt_pulse_d = 1'b0;
    overrun_d   = overrun_q;
    evt_count_d = evt_count_q;
    case (state_q)
      ST_IDLE: begin
        // out_ready is deliberately not looked at here.
        if (req_edge_s) begin
          out_data_d  = req_data;
          out_valid_d = 1'b1;
          evt_pulse_d = 1'b1;
          evt_count_d = evt_count_q + 16'd1;
          state_d     = ST_HOLD;
        end else begin
          state_d     = ST_IDLE;
        end
      end
      ST_HOLD: begin
        // A new toggle while a word is pending is dropped; the pending
        // word and its handshake proceed as if nothing happened.
        if (req_edge_s) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          ack_d       = ~ack_q;
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_HOLD;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sync_q      <= '0;
      prev_q      <= 1'b0;
      ack_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      evt_pulse_q <= 1'b0;
      overrun_q   <= 1'b0;
      evt_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      ack_q       <= ack_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      evt_pulse_q <= evt_pulse_d;
      overrun_q   <= overrun_d;
      evt_count_q <= evt_count_d;
    end
  end

  assign ack_tgl   = ack_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign evt_pulse = evt_pulse_q;
  assign overrun   = overrun_q;
  assign evt_count = evt_count_q;

endmodule

// File: doc/toggle_handshake_rx.md
# toggle_handshake_rx

Receive end of the two-phase toggle handshake whose send side is a `t_ff` driven by a request strobe. Synchronizes the incoming request toggle into the local `clk` domain and turns each toggle into one event. Captures the accompanying data word and presents it on a valid/ready output. Returns an acknowledge toggle once the word is consumed, and flags protocol overruns.

## Interface
Parameters:
- `WIDTH`, default 8: data word width.
- `SYNC_STAGES`, default 2: synchronizer flops on `req_tgl`, legal range 2..4.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req_tgl`, input, 1: request toggle from the remote `t_ff` q output. Asynchronous to `clk`. Each level change is one request.
- `req_data`, input, WIDTH: request payload. Stable from the `req_tgl` change until `ack_tgl` changes.
- `ack_tgl`, output, 1: acknowledge toggle. Changes once per consumed event.
- `out_valid`, output, 1: `out_data` holds an unconsumed word.
- `out_data`, output, WIDTH: captured payload.
- `out_ready`, input, 1: downstream accepts the word.
- `evt_pulse`, output, 1: one-cycle pulse per accepted event.
- `overrun`, output, 1: sticky protocol-violation flag.
- `evt_count`, output, 16: count of accepted events.

## Operation
- Reset values: all outputs are 0, including `ack_tgl`, `out_data`, `overrun` and `evt_count`. The synchronizer chain `sync[0..SYNC_STAGES-1]` and the edge-reference register `prev` are also 0.
- Synchronizer:
  - `sync[0]` samples `req_tgl` on every rising edge.
  - `sync[i]` samples `sync[i-1]`.
  - No other logic reads `req_tgl` directly.
- Edge detect: `edge = sync[SYNC_STAGES-1] ^ prev`, and `prev` loads `sync[SYNC_STAGES-1]` every cycle. Rising and falling toggles are equivalent.
- FSM states:
  - IDLE (reset state):
    - On `edge`: `out_data` loads `req_data`, `out_valid` goes to 1, `evt_pulse` goes to 1 for one cycle, and `evt_count` increments.
    - Then go to HOLD.
  - HOLD, on `out_valid && out_ready`:
    - `out_valid` goes to 0 and `ack_tgl` inverts.
    - Then go to IDLE.
  - HOLD, on `edge`:
    - Overrun: the sender toggled again before the acknowledge.
    - `overrun` goes to 1 and stays there until `rst`.
    - The payload is not captured, and neither `evt_pulse` nor `evt_count` changes.
    - The pending word and the handshake continue unaffected.
  - HOLD, `edge` and handshake in the same cycle:
    - Still an overrun; the new event is dropped.
    - The handshake completes normally and the FSM returns to IDLE.
- `out_data` holds its value after the handshake until the next capture.
- `evt_count` wraps from 0xFFFF to 0x0000 without a flag.
- `out_ready` is ignored in IDLE.
- Reset mid-operation: everything returns to reset values immediately, and a pending word is lost. System rule: both ends are reset together. If `req_tgl` is 1 when `rst` is released, that counts as one event.

## Timing
- Request latency: `req_tgl` changes before rising edge n.
  - `sync[SYNC_STAGES-1]` updates at edge n+SYNC_STAGES-1.
  - `out_valid`, `evt_pulse` and `out_data` update at edge n+SYNC_STAGES, i.e. 3 edges at the default.
  - Add one edge if the change violates setup at edge n.
- Ack latency: `ack_tgl` changes and `out_valid` falls at the first rising edge where `out_valid && out_ready` is sampled, giving a 1-cycle minimum hold.
- `evt_pulse` is exactly one `clk` cycle wide per accepted event.
- Minimum spacing between accepted events is SYNC_STAGES+2 cycles. The sender must wait for its synchronized view of `ack_tgl`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert `rst` mid-cycle with `req_tgl`=0 → all outputs 0 asynchronously, before the next edge; `evt_count`=0.
- Single event: with `SYNC_STAGES`=2 and `out_ready`=0, change `req_tgl` 0→1 with `req_data`=0xA5 → `out_valid`=1, `out_data`=0xA5, one-cycle `evt_pulse` and `evt_count`=1, all 3 edges later. Then raise `out_ready` → `ack_tgl`=1 and `out_valid`=0 on the next edge.
- Back-to-back: send 0x11, 0x22, 0x33 with toggles 1→0 and 0→1, each waiting for the ack toggle, `out_ready` held at 1 → the three words appear in order; `ack_tgl` ends at 1; `evt_count`=3; `overrun`=0.
- Overrun: send 0x5A, hold `out_ready`=0, toggle `req_tgl` again with `req_data`=0xFF → `overrun`=1, `out_data` stays 0x5A, `evt_count`=1. After `out_ready`=1 → `ack_tgl` toggles once and `overrun` stays 1.
- Reset mid-operation: with `out_valid`=1 and `evt_count`=7, pulse `rst` while `req_tgl`=1 → outputs clear. After release, one event is captured SYNC_STAGES+1 edges later and `evt_count`=1.
- Wrap: preload via 65535 events, or a force in the bench → the next event gives `evt_count`=0x0000 with `evt_pulse`=1.
